// File: rtl/fwd_src.sv
// Operand-forwarding source: holds the EX (two slots) and MEM destination tags,
// resolves operands X/Y from the returned one-hot selects, and flags load-use stalls.
module fwd_src #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_en,
  input  logic          flush,
  input  logic [RW-1:0] i_ra1,
  input  logic [RW-1:0] i_ra2,
  input  logic          i_valid1,
  input  logic          i_valid2,
  input  logic          i_load1,
  input  logic [DW-1:0] e_res1,
  input  logic [DW-1:0] e_res2,
  input  logic [DW-1:0] m_ldata,
  input  logic [DW-1:0] rf_x,
  input  logic [DW-1:0] rf_y,
  input  logic [3:0]    fwd_sel_x,
  input  logic [3:0]    fwd_sel_y,
  output logic [RW-1:0] e_ra1,
  output logic [RW-1:0] e_ra2,
  output logic          e_valid1,
  output logic          e_valid2,
  output logic [RW-1:0] m_ra,
  output logic          m_valid,
  output logic [DW-1:0] op_x,
  output logic [DW-1:0] op_y,
  output logic          stall
);

  logic [RW-1:0] r_e_ra1;
  logic [RW-1:0] r_e_ra2;
  logic          r_e_valid1;
  logic          r_e_valid2;
  logic          r_e_load1;
  logic [RW-1:0] r_m_ra;
  logic          r_m_valid;
  logic          r_m_load;
  logic [DW-1:0] r_m_data;

  logic          w_stall;
  logic [DW-1:0] w_mem_val;

  // Priority resolve of a possibly non-one-hot select: EX1 > EX2 > MEM > RF.
  function automatic logic [DW-1:0] pick(
    input logic [3:0]    sel,
    input logic [DW-1:0] ex1,
    input logic [DW-1:0] ex2,
    input logic [DW-1:0] mem,
    input logic [DW-1:0] rf
  );
    logic [DW-1:0] res;
    res = rf;
    if (sel[0])      res = ex1;
    else if (sel[1]) res = ex2;
    else if (sel[2]) res = mem;
    return res;
  endfunction

  // Only slot 1 can carry a load, so only an EX1 select can stall.
  assign w_stall   = r_e_valid1 & r_e_load1 & (fwd_sel_x[0] | fwd_sel_y[0]);
  assign w_mem_val = r_m_load ? m_ldata : r_m_data;

  always_comb begin
    op_x = pick(fwd_sel_x, e_res1, e_res2, w_mem_val, rf_x);
    op_y = pick(fwd_sel_y, e_res1, e_res2, w_mem_val, rf_y);
  end

  // Pipeline advance: EX slot 1 moves to MEM, slot 2 retires, ID loads EX or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_ra1    <= '0;
      r_e_ra2    <= '0;
      r_e_valid1 <= 1'b0;
      r_e_valid2 <= 1'b0;
      r_e_load1  <= 1'b0;
      r_m_ra     <= '0;
      r_m_valid  <= 1'b0;
      r_m_load   <= 1'b0;
      r_m_data   <= '0;
    end else if (pipe_en) begin
      r_m_ra    <= r_e_ra1;
      r_m_valid <= r_e_valid1;
      r_m_load  <= r_e_load1;
      r_m_data  <= e_res1;
      if (flush | w_stall) begin
        r_e_valid1 <= 1'b0;
        r_e_valid2 <= 1'b0;
        r_e_load1  <= 1'b0;
      end else begin
        r_e_ra1    <= i_ra1;
        r_e_ra2    <= i_ra2;
        r_e_valid1 <= i_valid1;
        r_e_valid2 <= i_valid2;
        r_e_load1  <= i_load1 & i_valid1;
      end
    end
  end

  assign e_ra1    = r_e_ra1;
  assign e_ra2    = r_e_ra2;
  assign e_valid1 = r_e_valid1;
  assign e_valid2 = r_e_valid2;
  assign m_ra     = r_m_ra;
  assign m_valid  = r_m_valid;
  assign stall    = w_stall;

endmodule

// File: tb/tb_fwd_src.sv
// Self-checking bench for fwd_src: mux vector table, directed pipeline
// sequences, and a randomized run against a small pipeline model.
module tb_fwd_src;

  logic        clk;
  logic        rst_n;
  logic        pipe_en;
  logic        flush;
  logic [3:0]  i_ra1;
  logic [3:0]  i_ra2;
  logic        i_valid1;
  logic        i_valid2;
  logic        i_load1;
  logic [31:0] e_res1;
  logic [31:0] e_res2;
  logic [31:0] m_ldata;
  logic [31:0] rf_x;
  logic [31:0] rf_y;
  logic [3:0]  fwd_sel_x;
  logic [3:0]  fwd_sel_y;
  logic [3:0]  e_ra1;
  logic [3:0]  e_ra2;
  logic        e_valid1;
  logic        e_valid2;
  logic [3:0]  m_ra;
  logic        m_valid;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic        stall;

  fwd_src #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
    .i_ra1(i_ra1), .i_ra2(i_ra2), .i_valid1(i_valid1), .i_valid2(i_valid2),
    .i_load1(i_load1), .e_res1(e_res1), .e_res2(e_res2), .m_ldata(m_ldata),
    .rf_x(rf_x), .rf_y(rf_y), .fwd_sel_x(fwd_sel_x), .fwd_sel_y(fwd_sel_y),
    .e_ra1(e_ra1), .e_ra2(e_ra2), .e_valid1(e_valid1), .e_valid2(e_valid2),
    .m_ra(m_ra), .m_valid(m_valid), .op_x(op_x), .op_y(op_y), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference pipeline contents: one instruction record per stage.
  typedef struct {
    logic [3:0]  tag1;
    logic [3:0]  tag2;
    logic        v1;
    logic        v2;
    logic        ld;
  } ex_t;
  typedef struct {
    logic [3:0]  tag;
    logic        v;
    logic        ld;
    logic [31:0] data;
  } mem_t;
  ex_t  mdl_ex;
  mem_t mdl_mem;

  typedef struct {
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic [31:0] exp_x;
    logic [31:0] exp_y;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_mem_val();
    return mdl_mem.ld ? m_ldata : mdl_mem.data;
  endfunction

  function automatic logic mdl_stall();
    return mdl_ex.v1 && mdl_ex.ld && (fwd_sel_x[0] || fwd_sel_y[0]);
  endfunction

  // Lowest-numbered set select bit names the source; nothing set means register file.
  function automatic logic [31:0] mdl_op(input logic [3:0] sel, input logic [31:0] rf);
    logic [31:0] src[4];
    src[0] = e_res1;
    src[1] = e_res2;
    src[2] = mdl_mem_val();
    src[3] = rf;
    for (int i = 0; i < 4; i++)
      if (sel[i]) return src[i];
    return rf;
  endfunction

  function automatic void mdl_reset();
    mdl_ex  = '{tag1: 4'd0, tag2: 4'd0, v1: 1'b0, v2: 1'b0, ld: 1'b0};
    mdl_mem = '{tag: 4'd0, v: 1'b0, ld: 1'b0, data: 32'd0};
  endfunction

  function automatic void mdl_advance();
    logic bubble;
    if (!pipe_en) return;
    bubble = flush || mdl_stall();
    mdl_mem = '{tag: mdl_ex.tag1, v: mdl_ex.v1, ld: mdl_ex.ld, data: e_res1};
    if (bubble) begin
      mdl_ex.v1 = 1'b0;
      mdl_ex.v2 = 1'b0;
      mdl_ex.ld = 1'b0;
    end else begin
      mdl_ex = '{tag1: i_ra1, tag2: i_ra2, v1: i_valid1, v2: i_valid2,
                 ld: i_load1 && i_valid1};
    end
  endfunction

  task automatic tick();
    mdl_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " e_ra1"},    32'(e_ra1),    32'(mdl_ex.tag1));
    chk({tag, " e_ra2"},    32'(e_ra2),    32'(mdl_ex.tag2));
    chk({tag, " e_valid1"}, 32'(e_valid1), 32'(mdl_ex.v1));
    chk({tag, " e_valid2"}, 32'(e_valid2), 32'(mdl_ex.v2));
    chk({tag, " m_ra"},     32'(m_ra),     32'(mdl_mem.tag));
    chk({tag, " m_valid"},  32'(m_valid),  32'(mdl_mem.v));
    chk({tag, " op_x"},     op_x,          mdl_op(fwd_sel_x, rf_x));
    chk({tag, " op_y"},     op_y,          mdl_op(fwd_sel_y, rf_y));
    chk({tag, " stall"},    32'(stall),    32'(mdl_stall()));
  endtask

  task automatic issue(input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic v1, input logic v2, input logic ld);
    i_ra1 = ra1; i_ra2 = ra2; i_valid1 = v1; i_valid2 = v2; i_load1 = ld;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 4'b1000, 32'hAAAA_0001, 32'h2222_2222};
    vecs[1] = '{4'b0011, 4'b0100, 32'hAAAA_0001, 32'h0000_0000};
    vecs[2] = '{4'b0110, 4'b0010, 32'hBBBB_0002, 32'hBBBB_0002};
    vecs[3] = '{4'b1100, 4'b0000, 32'h0000_0000, 32'h2222_2222};
    vecs[4] = '{4'b0000, 4'b1111, 32'h1111_1111, 32'hAAAA_0001};
    vecs[5] = '{4'b1000, 4'b1010, 32'h1111_1111, 32'hBBBB_0002};

    // Reset with random inputs.
    rst_n = 1'b0;
    pipe_en = 1'b1; flush = $urandom_range(0, 1) == 1;
    issue(4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1);
    e_res1 = $urandom; e_res2 = $urandom; m_ldata = $urandom;
    rf_x = 32'h1234; rf_y = $urandom;
    fwd_sel_x = 4'b1000; fwd_sel_y = 4'b0001;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst e_valid1", 32'(e_valid1), 32'd0);
    chk("rst e_valid2", 32'(e_valid2), 32'd0);
    chk("rst m_valid",  32'(m_valid),  32'd0);
    chk("rst stall",    32'(stall),    32'd0);
    chk("rst op_x",     op_x,          32'h1234);
    rst_n = 1'b1;

    // Select-priority table on the post-reset state (MEM value is 0).
    e_res1 = 32'hAAAA_0001; e_res2 = 32'hBBBB_0002; m_ldata = 32'hCCCC_0003;
    rf_x = 32'h1111_1111; rf_y = 32'h2222_2222;
    for (int i = 0; i < 6; i++) begin
      fwd_sel_x = vecs[i].sx; fwd_sel_y = vecs[i].sy;
      #1;
      chk($sformatf("vec%0d op_x", i), op_x, vecs[i].exp_x);
      chk($sformatf("vec%0d op_y", i), op_y, vecs[i].exp_y);
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
    end

    // ALU forward from EX1, then from MEM.
    flush = 1'b0; pipe_en = 1'b1;
    fwd_sel_x = 4'b1000; fwd_sel_y = 4'b1000;
    issue(4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    e_res1 = 32'hA5A5_0001; fwd_sel_x = 4'b0001;
    #1;
    chk("alu op_x ex1", op_x, 32'hA5A5_0001);
    chk("alu stall", 32'(stall), 32'd0);
    tick();
    fwd_sel_x = 4'b1000; fwd_sel_y = 4'b0100; e_res1 = 32'h0;
    #1;
    chk("alu m_ra", 32'(m_ra), 32'd3);
    chk("alu m_valid", 32'(m_valid), 32'd1);
    chk("alu op_y mem", op_y, 32'hA5A5_0001);

    // Load-use: one stall cycle, then MEM returns load data.
    fwd_sel_y = 4'b1000;
    issue(4'd5, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    fwd_sel_y = 4'b0001;
    #1;
    chk("ldu stall", 32'(stall), 32'd1);
    tick();
    chk("ldu e_valid1", 32'(e_valid1), 32'd0);
    chk("ldu m_ra", 32'(m_ra), 32'd5);
    m_ldata = 32'hDEAD_BEEF; fwd_sel_y = 4'b0100;
    #1;
    chk("ldu op_y", op_y, 32'hDEAD_BEEF);
    chk("ldu stall clear", 32'(stall), 32'd0);

    // Dual destination: slot 2 forwards from EX but never reaches MEM.
    fwd_sel_x = 4'b1000; fwd_sel_y = 4'b1000;
    issue(4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    fwd_sel_x = 4'b0010; e_res2 = 32'h0000_0040;
    #1;
    chk("dual op_x", op_x, 32'h0000_0040);
    chk("dual e_ra2", 32'(e_ra2), 32'd7);
    chk("dual e_valid2", 32'(e_valid2), 32'd1);
    tick();
    chk("dual m_ra", 32'(m_ra), 32'd2);
    chk("dual e_valid2 gone", 32'(e_valid2), 32'd0);

    // Flush kills the issue but MEM still takes the old EX; then hold.
    fwd_sel_x = 4'b1000;
    issue(4'd9, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    issue(4'd4, 4'd6, 1'b1, 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    chk("flush e_valid1", 32'(e_valid1), 32'd0);
    chk("flush e_valid2", 32'(e_valid2), 32'd0);
    chk("flush m_ra", 32'(m_ra), 32'd9);
    chk("flush m_valid", 32'(m_valid), 32'd1);
    pipe_en = 1'b0;
    issue(4'd11, 4'd12, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("hold e_ra1", 32'(e_ra1), 32'd9);
    chk("hold e_valid1", 32'(e_valid1), 32'd0);
    chk("hold m_ra", 32'(m_ra), 32'd9);
    chk("hold m_valid", 32'(m_valid), 32'd1);

    // Stall held under PIPE_EN=0, then async reset between edges.
    pipe_en = 1'b1;
    issue(4'd6, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    issue(4'd8, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    pipe_en = 1'b0; fwd_sel_x = 4'b0001;
    repeat (2) tick();
    chk("hstall stall", 32'(stall), 32'd1);
    chk("hstall m_valid", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("areset stall", 32'(stall), 32'd0);
    chk("areset m_valid", 32'(m_valid), 32'd0);
    chk("areset e_valid1", 32'(e_valid1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; pipe_en = 1'b1; fwd_sel_x = 4'b1000;
    issue(4'd12, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("post-rst e_ra1", 32'(e_ra1), 32'd12);
    chk("post-rst e_valid1", 32'(e_valid1), 32'd1);

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      pipe_en = $urandom_range(0, 3) != 0;
      flush   = $urandom_range(0, 6) == 0;
      issue(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) == 0);
      e_res1 = $urandom; e_res2 = $urandom; m_ldata = $urandom;
      rf_x = $urandom; rf_y = $urandom;
      fwd_sel_x = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      fwd_sel_y = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      #2;
      chk_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
